// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: applies one power-of-two stage (16, 8, 4, 2, 1) per clock to an
// accumulator, replacing a combinational barrel shifter. Handshake is start / busy / done.
module shift_sequencer #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  rem_q, rem_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] data_out_q, data_out_d;
    logic [2:0]  stage_q, stage_d;

    logic [2:0]  top_bit;
    logic [2:0]  k;
    logic [4:0]  amt;
    logic [31:0] shifted;

    // Highest set bit of the remaining shift amount.
    always_comb begin
        top_bit = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (rem_q[i]) top_bit = 3'(i);
        end
    end

    // 2^k doubles as the one-hot mask selecting bit k of rem.
    always_comb begin
        k   = SKIP_ZERO ? top_bit : stage_q;
        amt = 5'd1 << k;
        unique case (op_q)
            2'b00:   shifted = acc_q << amt;
            2'b01:   shifted = acc_q >> amt;
            2'b10:   shifted = $signed(acc_q) >>> amt;
            default: shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        stage_d    = stage_q;
        data_out_d = data_out_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) state_d = StIdle;
                if (start) begin
                    op_d    = op;
                    rem_d   = shamt;
                    acc_d   = data_in;
                    stage_d = 3'd4;
                    if (op == 2'b11 || (SKIP_ZERO && shamt == 5'd0)) begin
                        state_d    = StDone;
                        data_out_d = data_in;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                acc_d = ((rem_q & amt) != 5'd0) ? shifted : acc_q;
                if (SKIP_ZERO) begin
                    rem_d = rem_q & ~amt;
                    if (rem_d == 5'd0) begin
                        state_d    = StDone;
                        data_out_d = acc_d;
                    end
                end else begin
                    stage_d = stage_q - 3'd1;
                    if (stage_q == 3'd0) begin
                        state_d    = StDone;
                        data_out_d = acc_d;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= 2'b00;
            rem_q      <= 5'd0;
            acc_q      <= 32'd0;
            stage_q    <= 3'd0;
            data_out_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            stage_q    <= stage_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = (state_q == StShift);
    assign done     = (state_q == StDone);

endmodule
